// File: rtl/seq_match_controller_if.sv
// Word-stream handshake between a producer (master) and seq_match_controller (slave).
interface seq_match_controller_if #(
    parameter int unsigned WORD_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/seq_match_controller.sv
// Word-to-serial sequencer with a programmable pattern detector, saturating match counter and
// sticky threshold interrupt. Define SEQ_MATCH_NONOVERLAP_EN for non-overlapping detection.
module seq_match_controller #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned PATTERN_W = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0]     cfg_threshold,
    seq_match_controller_if.slave s_bus,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 irq,
    input  logic                 irq_clr,
    output logic                 busy
);
    localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned SEEN_W = $clog2(PATTERN_W + 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t               state;
    logic [WORD_W-1:0]    shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic [PATTERN_W-1:0] pattern;
    logic [PATTERN_W-1:0] hist;
    logic [SEEN_W-1:0]    seen;

    logic [PATTERN_W-1:0] hist_nxt;
    logic [SEEN_W-1:0]    seen_nxt;
    logic                 hit;
    logic                 cnt_max;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 irq_set;

    // The shift register MSB is the serial output, so bit_out comes straight from a flop.
    assign bit_out = shreg[WORD_W-1];

    // Match evaluation for the current shift edge; abort suppresses it.
    always_comb begin
        hist_nxt = {hist[PATTERN_W-2:0], bit_out};
        seen_nxt = (seen == SEEN_W'(PATTERN_W)) ? seen : seen + SEEN_W'(1);
        hit      = (state == SHIFT) && !abort && (hist_nxt == pattern) &&
                   (seen_nxt == SEEN_W'(PATTERN_W));
        cnt_max  = &match_count;
        cnt_inc  = match_count + CNT_W'(1);
        irq_set  = hit && !cnt_max && (cfg_threshold != '0) && (cnt_inc == cfg_threshold);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            pattern       <= '0;
            hist          <= '0;
            seen          <= '0;
            s_bus.s_ready <= 1'b0;
            bit_valid     <= 1'b0;
            match_pulse   <= 1'b0;
            match_count   <= '0;
            irq           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            irq         <= irq_set | (irq & ~irq_clr);
            if (abort) begin
                state         <= IDLE;
                shreg         <= '0;
                s_bus.s_ready <= 1'b0;
                bit_valid     <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state         <= ARMED;
                            pattern       <= cfg_pattern;
                            hist          <= '0;
                            seen          <= '0;
                            match_count   <= '0;
                            s_ready_set();
                            busy          <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (s_bus.s_valid) begin
                            state         <= SHIFT;
                            shreg         <= s_bus.s_data;
                            bit_idx       <= '0;
                            s_bus.s_ready <= 1'b0;
                            bit_valid     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shreg   <= shreg << 1;
                        bit_idx <= bit_idx + IDX_W'(1);
`ifdef SEQ_MATCH_NONOVERLAP_EN
                        hist    <= hit ? '0 : hist_nxt;
                        seen    <= hit ? '0 : seen_nxt;
`else
                        hist    <= hist_nxt;
                        seen    <= seen_nxt;
`endif
                        if (hit) begin
                            match_pulse <= 1'b1;
                            if (!cnt_max) match_count <= cnt_inc;
                        end
                        // Last bit of the word: hand back to ARMED for the next one.
                        if (bit_idx == IDX_W'(WORD_W - 1)) begin
                            state         <= ARMED;
                            bit_valid     <= 1'b0;
                            s_bus.s_ready <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    task automatic s_ready_set();
        s_bus.s_ready <= 1'b1;
    endtask
endmodule

// File: tb/tb_seq_match_controller.sv
// Self-checking bench for seq_match_controller: vector table, directed corner cases and
// randomized traffic checked cycle-by-cycle against a bit-stream reference model.
module tb_seq_match_controller;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned PATTERN_W = 4;
    localparam int unsigned CNT_W     = 8;
`ifdef SEQ_MATCH_NONOVERLAP_EN
    localparam bit NONOVL = 1'b1;
`else
    localparam bit NONOVL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             irq_clr_drv = 1'b0;
    logic             rnd_clr = 1'b0;
    logic             rand_clr_en = 1'b0;
    logic             irq_clr;
    logic [3:0]       cfg_pattern = 4'b0;
    logic [7:0]       cfg_threshold = 8'h0;
    logic             bit_out, bit_valid, match_pulse, irq, busy;
    logic [CNT_W-1:0] match_count;

    seq_match_controller_if #(.WORD_W(WORD_W)) s_bus ();

    assign irq_clr = rand_clr_en ? rnd_clr : irq_clr_drv;

    seq_match_controller #(.WORD_W(WORD_W), .PATTERN_W(PATTERN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_threshold(cfg_threshold), .s_bus(s_bus),
        .bit_out(bit_out), .bit_valid(bit_valid), .match_pulse(match_pulse),
        .match_count(match_count), .irq(irq), .irq_clr(irq_clr), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) rnd_clr <= ($urandom_range(0, 7) == 0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the serial stream as a list of bits, matches found by comparing its tail.
    logic        exp_bits[$];
    logic        stream[$];
    int          seg, nbits, cyc, m_cnt, p_idx;
    logic        m_idle = 1'b1, m_irq, m_pulse, m_set, eb;
    logic [3:0]  m_pat, p_pat;
    logic        p_bv, p_start, p_abort, p_clr, p_match;
    logic [7:0]  p_thr;
    logic [63:0] pulse_log;
    int          bit_cyc[64];

    function automatic logic tail_matches();
        if (stream.size() - seg < int'(PATTERN_W)) return 1'b0;
        for (int i = 0; i < int'(PATTERN_W); i++)
            if (stream[stream.size() - 1 - i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_bits.delete(); stream.delete();
            m_idle = 1'b1; m_cnt = 0; m_irq = 1'b0; seg = 0; nbits = 0; pulse_log = '0;
            p_bv = 0; p_start = 0; p_abort = 0; p_clr = 0; p_match = 0; p_thr = '0; p_pat = '0;
        end else begin
            cyc++;
            m_pulse = 1'b0; m_set = 1'b0;
            if (p_abort) begin
                m_idle = 1'b1; exp_bits.delete();
            end else if (m_idle) begin
                if (p_start) begin
                    m_idle = 1'b0; m_cnt = 0; m_pat = p_pat;
                    stream.delete(); seg = 0; nbits = 0; pulse_log = '0;
                end
            end else if (p_bv && p_match) begin
                m_pulse = 1'b1;
                if (m_cnt < 255) begin
                    m_cnt++;
                    m_set = (p_thr != 0) && (m_cnt == int'(p_thr));
                end
            end
            if (p_bv && match_pulse && p_idx < 64) pulse_log[p_idx] = 1'b1;
            m_irq = m_set | (m_irq & ~p_clr);
            chk("match_pulse", 32'(match_pulse), 32'(m_pulse));
            chk("match_count", 32'(match_count), 32'(m_cnt));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("busy", 32'(busy), 32'(!m_idle));
            p_match = 1'b0;
            if (bit_valid) begin
                if (exp_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bit actual=bit_valid expected=idle t=%0t", $time);
                end else begin
                    eb = exp_bits.pop_front();
                    chk("bit_out", 32'(bit_out), 32'(eb));
                    stream.push_back(eb);
                    p_match = tail_matches();
                    if (p_match && NONOVL) seg = stream.size();
                    p_idx = nbits;
                    if (nbits < 64) bit_cyc[nbits] = cyc;
                    nbits++;
                end
            end
            p_bv = bit_valid; p_start = start; p_abort = abort; p_clr = irq_clr;
            p_thr = cfg_threshold; p_pat = cfg_pattern;
        end
    end

    // Driver tasks are entered 1 time unit after a rising edge.
    task automatic do_start(input logic [3:0] p);
        cfg_pattern = p; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok = 1'b0;
        s_bus.s_valid = 1'b1; s_bus.s_data = w;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (s_bus.s_ready) begin
                @(posedge clk);
                ok = 1'b1;
                for (int b = 7; b >= 0; b--) exp_bits.push_back(w[b]);
                #1;
            end
        end
        s_bus.s_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_ready expected=ready word=%0h", w);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (exp_bits.size() == 0 && !bit_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_bits_left expected=0", exp_bits.size());
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0]  pat;
        int          nw;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          cnt;
        logic [15:0] mask;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        s_bus.s_valid = 1'b0; s_bus.s_data = '0;
        tbl[0] = '{4'b1011, 1, 8'hB6, 8'h00, 2, 16'h0048};
        tbl[3] = '{4'b1011, 1, 8'h5A, 8'h00, 1, 16'h0010};
        tbl[5] = '{4'b1011, 2, 8'h01, 8'h60, 1, 16'h0400};
        tbl[7] = '{4'b1001, 2, 8'h09, 8'h90, 2, 16'h0880};
`ifdef SEQ_MATCH_NONOVERLAP_EN
        tbl[0] = '{4'b1011, 1, 8'hB6, 8'h00, 1, 16'h0008};
        tbl[1] = '{4'b1111, 1, 8'hFF, 8'h00, 2, 16'h0088};
        tbl[2] = '{4'b0000, 1, 8'h00, 8'h00, 2, 16'h0088};
        tbl[4] = '{4'b1010, 1, 8'hAA, 8'h00, 2, 16'h0088};
        tbl[6] = '{4'b1111, 2, 8'h0F, 8'hF0, 2, 16'h0880};
`else
        tbl[1] = '{4'b1111, 1, 8'hFF, 8'h00, 5, 16'h00F8};
        tbl[2] = '{4'b0000, 1, 8'h00, 8'h00, 5, 16'h00F8};
        tbl[4] = '{4'b1010, 1, 8'hAA, 8'h00, 3, 16'h00A8};
        tbl[6] = '{4'b1111, 2, 8'h0F, 8'hF0, 5, 16'h0F80};
`endif

        // Reset state
        #2;
        chk("rst_bit_valid", 32'(bit_valid), 0); chk("rst_bit_out", 32'(bit_out), 0);
        chk("rst_s_ready", 32'(s_bus.s_ready), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(match_count), 0); chk("rst_irq", 32'(irq), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            do_abort();
            do_start(tbl[i].pat);
            send_word(tbl[i].w0);
            if (tbl[i].nw > 1) send_word(tbl[i].w1);
            drain();
            chk($sformatf("tbl%0d_count", i), 32'(match_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_pulses", i), pulse_log[31:0], {16'h0, tbl[i].mask});
        end

        // Back-to-back words: one ARMED bubble, 9 cycles per word
        do_abort();
        do_start(4'b1011);
        send_word(8'h01);
        send_word(8'h60);
        drain();
        chk("bubble_gap", 32'(bit_cyc[8] - bit_cyc[7]), 2);
        chk("word_period", 32'(bit_cyc[15] - bit_cyc[7]), 9);
        chk("boundary_count", 32'(match_count), 1);

        // Threshold interrupt, clear, and set-beats-clear
        cfg_threshold = 8'd2;
        do_abort();
        do_start(4'b1011);
        send_word(8'hB6);
        drain();
        chk("irq_at_threshold", 32'(irq), 1);
        irq_clr_drv = 1'b1;
        @(posedge clk); #1 irq_clr_drv = 1'b0;
        chk("irq_cleared", 32'(irq), 0);
        cfg_threshold = 8'd1;
        do_abort();
        do_start(4'b1011);
        irq_clr_drv = 1'b1;
        send_word(8'hB6);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (match_pulse) begin
                    seen = 1'b1;
                    chk("irq_set_wins", 32'(irq), 1);
                end
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL pulse_timeout actual=none expected=match_pulse");
            end
        end
        @(posedge clk); #1;
        drain();
        irq_clr_drv = 1'b0;

        // Abort mid-word; start outside IDLE ignored; abort beats start
        cfg_threshold = 8'd0;
        do_abort();
        do_start(4'b1011);
        send_word(8'hB6);
        drain();
        do_start(4'b0000);
        @(negedge clk);
        chk("start_ignored_count", 32'(match_count), 2);
        @(posedge clk); #1;
        send_word(8'hB6);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_bit_valid", 32'(bit_valid), 0);
        chk("abort_s_ready", 32'(s_bus.s_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_count_held", 32'(match_count), 2);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_ready", 32'(s_bus.s_ready), 0);
        @(posedge clk); #1;

        // Reset in the middle of a word
        cfg_threshold = 8'd1;
        do_start(4'b1011);
        send_word(8'hB6);
        send_word(8'hB6);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("arst_bit_valid", 32'(bit_valid), 0); chk("arst_bit_out", 32'(bit_out), 0);
        chk("arst_pulse", 32'(match_pulse), 0); chk("arst_s_ready", 32'(s_bus.s_ready), 0);
        chk("arst_busy", 32'(busy), 0); chk("arst_count", 32'(match_count), 0);
        chk("arst_irq", 32'(irq), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Long stream with s_valid held high: saturation at 255
        cfg_threshold = 8'd0;
        do_start(4'b1011);
        for (int i = 0; i < 130; i++) send_word(8'hBB);
        drain();
        chk("saturated_count", 32'(match_count), 255);

        // Randomized traffic against the model
        rand_clr_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            cfg_threshold = 8'($urandom_range(0, 6));
            do_abort();
            do_start(4'($urandom));
            for (int w = 0; w < int'($urandom_range(4, 12)); w++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #0 send_word(8'($urandom));
            end
            drain();
        end
        rand_clr_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
